// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//
// MM:SS stopwatch counting in BCD, from 00:00 up to 59:59, then wrapping to
// 00:00. It counts one second for each rising edge of the slow tick_in square
// wave. tick_in comes from a divided clock domain, so it is first passed through
// a SYNC_STAGES-deep synchronizer and then through a rising-edge detector.
//
// Parameters
//   SYNC_STAGES  number of synchronizer flops on tick_in (legal range 2..4)
//
// Ports
//   clk_in      in   system clock; all state changes on its rising edge
//   reset       in   asynchronous active-low reset
//   tick_in     in   slow time base; one rising edge counts one second
//   start_stop  in   single-cycle pulse that toggles STOPPED/RUNNING
//   clear       in   zeroes the count and stops; overrides everything but reset
//   sec_u       out  seconds units digit, 0..9
//   sec_t       out  seconds tens digit, 0..5
//   min_u       out  minutes units digit, 0..9
//   min_t       out  minutes tens digit, 0..5
//   running     out  high while the FSM is in RUNNING
//   wrap        out  one-cycle pulse after the roll-over from 59:59 to 00:00
//
// Every output comes straight from a flop. No input reaches an output
// through combinational logic alone.
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_u,
  output logic [2:0] sec_t,
  output logic [3:0] min_u,
  output logic [2:0] min_t,
  output logic       running,
  output logic       wrap
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // tick_in synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick;

  // The edge history updates every cycle, whatever the FSM state is. An edge
  // seen while stopped is therefore used up and cannot be counted after a
  // restart.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      // NOTE: the synchronizer and history flops are reset as well, so an edge
      // captured before reset cannot leak into the count afterwards.
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's pre-edge value; blocking ones would collapse the chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

  // ---------------------------------------------------------------------------
  // Run/stop FSM
  // ---------------------------------------------------------------------------
  state_e state_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= STOPPED;
    end else if (clear) begin
      state_q <= STOPPED;
    end else if (start_stop) begin
      state_q <= (state_q == RUNNING) ? STOPPED : RUNNING;
    end
  end

  assign running = (state_q == RUNNING);

  // ---------------------------------------------------------------------------
  // BCD digit chain
  // ---------------------------------------------------------------------------
  logic [3:0] sec_u_q, sec_u_d;
  logic [2:0] sec_t_q, sec_t_d;
  logic [3:0] min_u_q, min_u_d;
  logic [2:0] min_t_q, min_t_d;
  logic       wrap_q,  wrap_d;

  // The tick is judged against state_q, which is the state at the start of
  // the cycle. If start_stop arrives on the same edge as a tick, the tick
  // follows the pre-toggle state.
  // Each digit is tested with ">= limit" and not "== limit". If a digit ever
  // held an illegal value, the next tick would still return it to 0 and no
  // digit could climb further out of range.
  always_comb begin
    // NOTE: every _d signal gets a default before any branch. Each path then
    // assigns it, so no latch is inferred.
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    wrap_d  = 1'b0;

    if (clear) begin
      sec_u_d = '0;
      sec_t_d = '0;
      min_u_d = '0;
      min_t_d = '0;
    end else if (tick && (state_q == RUNNING)) begin
      if (sec_u_q < 4'd9) begin
        sec_u_d = sec_u_q + 4'd1;
      end else begin
        sec_u_d = '0;
        if (sec_t_q < 3'd5) begin
          sec_t_d = sec_t_q + 3'd1;
        end else begin
          sec_t_d = '0;
          if (min_u_q < 4'd9) begin
            min_u_d = min_u_q + 4'd1;
          end else begin
            min_u_d = '0;
            if (min_t_q < 3'd5) begin
              min_t_d = min_t_q + 3'd1;
            end else begin
              min_t_d = '0;
              wrap_d  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sec_u_q <= '0;
      sec_t_q <= '0;
      min_u_q <= '0;
      min_t_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sec_u_q <= sec_u_d;
      sec_t_q <= sec_t_d;
      min_u_q <= min_u_d;
      min_t_q <= min_t_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sec_u = sec_u_q;
  assign sec_t = sec_t_q;
  assign min_u = min_u_q;
  assign min_t = min_t_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd
//
// Scoreboarded bench for stopwatch_bcd. The driver updates a reference model
// once for every clock edge. The model keeps the elapsed time as a plain
// integer number of seconds (0..3599). A tick_in rising edge counts only if
// it was sampled exactly SYNC clock edges earlier. For every edge the model
// pushes the expected {display, running, wrap} onto a queue. A separate
// monitor pops one entry just after each rising edge and compares it with the
// outputs. Directed checks at the milestones compare the outputs with literal
// BCD values, and the async-reset checks are made between clock edges.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd;

  localparam int SYNC = 2;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_u;
  logic [2:0] sec_t;
  logic [3:0] min_u;
  logic [2:0] min_t;
  logic       running;
  logic       wrap;

  stopwatch_bcd #(.SYNC_STAGES(SYNC)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .sec_u      (sec_u),
    .sec_t      (sec_t),
    .min_u      (min_u),
    .min_t      (min_t),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] dut_disp;
  assign dut_disp = {1'b0, min_t, min_u, 1'b0, sec_t, sec_u};

  typedef struct {
    logic [15:0] disp;
    logic        run;
    logic        wrp;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_total;
  bit m_run;
  bit m_wrap;
  bit m_hist[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    logic [15:0] r;
    r = {1'b0, 3'(t / 600), 4'((t / 60) % 10), 1'b0, 3'((t / 10) % 6), 4'(t % 10)};
    return r;
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_run   = 1'b0;
    m_wrap  = 1'b0;
    m_hist.delete();
    for (int i = 0; i <= SYNC; i++) m_hist.push_back(1'b0);
  endtask

  // Drives the inputs for the next rising edge and records what that edge
  // must produce.
  task automatic apply(input bit ss, input bit clr, input bit tk);
    bit   ev;
    exp_t e;
    start_stop = ss;
    clear      = clr;
    tick_in    = tk;
    m_hist.push_back(tk);
    ev = m_hist[m_hist.size() - 1 - SYNC] && !m_hist[m_hist.size() - 2 - SYNC];
    void'(m_hist.pop_front());
    if (clr) begin
      m_total = 0;
      m_run   = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (ev && m_run) begin
        m_total = (m_total + 1) % 3600;
        m_wrap  = (m_total == 0);
      end
      if (ss) m_run = !m_run;
    end
    e.disp = to_bcd(m_total);
    e.run  = m_run;
    e.wrp  = m_wrap;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit ss, input bit clr, input bit tk);
    @(negedge clk_in);
    apply(ss, clr, tk);
  endtask

  // One tick_in pulse. The detected tick lands on the last edge of this
  // task, the same edge that carries ss/clr.
  task automatic tick_cmd(input bit ss, input bit clr);
    cycle(1'b0, 1'b0, 1'b1);
    for (int k = 1; k < SYNC; k++) cycle(1'b0, 1'b0, 1'b0);
    cycle(ss, clr, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk_in);
    #2;
  endtask

  task automatic advance_to(input int target);
    for (int n = 0; n < 4000 && m_total != target; n++) tick_cmd(1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per modelled edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_disp",    dut_disp,          e.disp);
        check("sb_running", {15'b0, running},  {15'b0, e.run});
        check("sb_wrap",    {15'b0, wrap},     {15'b0, e.wrp});
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit tk_lvl;
    reset      = 1'b0;
    tick_in    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk_in);
    #2;
    check("reset_disp",    dut_disp,         16'h0000);
    check("reset_running", {15'b0, running}, 16'h0000);
    check("reset_wrap",    {15'b0, wrap},    16'h0000);
    @(negedge clk_in);
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0);

    // Start, then three ticks
    cycle(1'b1, 1'b0, 1'b0);
    settle();
    check("start_running", {15'b0, running}, 16'h0001);
    for (int i = 1; i <= 3; i++) begin
      tick_cmd(1'b0, 1'b0);
      settle();
      check("count_up", dut_disp, 16'(i));
    end

    // Decimal carries
    advance_to(9);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("carry_sec_t", dut_disp, 16'h0010);
    advance_to(59);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("carry_min_u", dut_disp, 16'h0100);
    advance_to(599);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("carry_min_t", dut_disp, 16'h1000);

    // Stop/hold/restart, and a tick coinciding with stop
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    advance_to(5);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (4) tick_cmd(1'b0, 1'b0);
    settle();
    check("stopped_hold",    dut_disp,         16'h0005);
    check("stopped_running", {15'b0, running}, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("restart_resume", dut_disp,         16'h0006);
    check("restart_run",    {15'b0, running}, 16'h0001);
    tick_cmd(1'b1, 1'b0);
    settle();
    check("tick_with_stop",     dut_disp,         16'h0007);
    check("tick_with_stop_run", {15'b0, running}, 16'h0000);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    settle();
    check("idle_hold", dut_disp, 16'h0007);

    // clear beats start_stop and tick on the same edge
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    advance_to(754);
    settle();
    check("at_1234", dut_disp, 16'h1234);
    tick_cmd(1'b1, 1'b1);
    settle();
    check("clear_disp",    dut_disp,         16'h0000);
    check("clear_running", {15'b0, running}, 16'h0000);
    check("clear_wrap",    {15'b0, wrap},    16'h0000);

    // Roll-over from 59:59
    cycle(1'b1, 1'b0, 1'b0);
    advance_to(3598);
    settle();
    check("at_5958", dut_disp, 16'h5958);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("at_5959", dut_disp, 16'h5959);
    check("pre_wrap_low", {15'b0, wrap}, 16'h0000);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("wrap_disp", dut_disp,      16'h0000);
    check("wrap_high", {15'b0, wrap}, 16'h0001);
    cycle(1'b0, 1'b0, 1'b0);
    settle();
    check("wrap_one_cycle", {15'b0, wrap}, 16'h0000);
    tick_cmd(1'b0, 1'b0);
    settle();
    check("count_after_wrap", dut_disp, 16'h0001);

    // Random commands and tick_in activity
    tk_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) tk_lvl = !tk_lvl;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, tk_lvl);
    end

    // Async reset mid-count, released with tick_in high
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) tick_cmd(1'b0, 1'b0);
    @(posedge clk_in);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_disp",    dut_disp,         16'h0000);
    check("async_rst_running", {15'b0, running}, 16'h0000);
    check("async_rst_wrap",    {15'b0, wrap},    16'h0000);
    tick_in = 1'b1;
    repeat (2) @(posedge clk_in);
    model_reset();
    @(negedge clk_in);
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    settle();
    check("post_rst_disp",    dut_disp,         16'h0000);
    check("post_rst_running", {15'b0, running}, 16'h0000);

    repeat (4) @(posedge clk_in);
    #2;
    check("sb_drained", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on tick_in; legal range 2..4.
REQ-002 Port: clk_in  input  1  system clock; all state is clocked on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; one clock; the polarity and synchronicity are fixed.
REQ-004 Port: tick_in  input  1  slow square-wave time base from the clock divider (clk_out); one rising edge means one count.
REQ-005 Port: start_stop  input  1  synchronous single-cycle command pulse that toggles run state.
REQ-006 Port: clear  input  1  synchronous command that zeroes the count and stops.
REQ-007 Port: sec_u  output  4  BCD seconds units, range 0..9.
REQ-008 Port: sec_t  output  3  BCD seconds tens, range 0..5.
REQ-009 Port: min_u  output  4  BCD minutes units, range 0..9.
REQ-010 Port: min_t  output  3  BCD minutes tens, range 0..5.
REQ-011 Port: running  output  1  high while the FSM is in RUNNING.
REQ-012 Port: wrap  output  1  one-cycle pulse when the count rolls over from 59:59 to 00:00.

Function
REQ-013 tick_in SHALL pass through SYNC_STAGES flops, then through a rising-edge detector (last sync stage high, previous value low) that produces an internal one-cycle tick.
REQ-014 The edge detector history SHALL update every cycle regardless of FSM state, so an edge that arrives while stopped is never counted later.
REQ-015 The FSM SHALL have exactly two states, STOPPED and RUNNING; reset and clear force STOPPED; each cycle with start_stop=1 and clear=0 toggles the state.
REQ-016 Digits SHALL advance by one second only on a cycle with the internal tick high while the FSM is in RUNNING, judged by the state at the start of that cycle.
REQ-017 Carry chain: sec_u 9->0 increments sec_t; sec_t 5->0 increments min_u; min_u 9->0 increments min_t; min_t 5->0 wraps; the carry chain is decimal only, and no digit may ever hold a value outside its range.
REQ-018 Latency: a counted tick_in edge SHALL update the digits on the SYNC_STAGES-th rising clk_in edge after the edge that first samples tick_in high.
REQ-019 On the increment from 59:59, all digits SHALL become 0 and wrap SHALL be high for exactly the following cycle; wrap is 0 at all other times; counting continues.
REQ-020 clear=1 SHALL set all digits to 0, running=0 and wrap=0 on the next edge, overriding start_stop and tick in the same cycle.
REQ-021 When start_stop and tick coincide with clear=0, the tick SHALL be applied according to the pre-toggle state, and the state toggles on the same edge.
REQ-022 While STOPPED, digits SHALL hold their value indefinitely; a restart resumes from the held value.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 Asserting reset (low) SHALL immediately and asynchronously force: digits 0, running=0, wrap=0, all synchronizer flops 0, edge history 0.
REQ-025 Reset SHALL override clear, start_stop and tick at all times, including mid-count and mid-wrap.
REQ-026 After reset deassertion with tick_in already high, the detector MAY see one rising edge; the FSM is STOPPED, so the digits SHALL stay 00:00.

Verification
REQ-027 Reset, pulse start_stop, apply 3 tick_in rising edges -> running=1, display 00:03; each update occurs exactly SYNC_STAGES clk_in edges after sampling.
REQ-028 Preload to 59:58 by ticks, apply 2 edges -> 59:59, then 00:00 with wrap high for exactly 1 cycle.
REQ-029 Running at 00:09, one tick -> 00:10; at 00:59, one tick -> 01:00; at 09:59, one tick -> 10:00.
REQ-030 Running at 00:05: stop, apply 4 tick edges, restart, apply 1 edge -> 00:06; also a tick coincident with the stop pulse is counted (00:06 -> 00:07 path).
REQ-031 At 12:34 running, assert clear together with start_stop and a tick -> next cycle 00:00, running=0, wrap=0.
REQ-032 Assert reset low mid-count, asynchronously between clk_in edges -> outputs 0 before the next edge; release with tick_in high -> display remains 00:00, running=0.
